// File: rtl/cmp_pkg.sv
// Shared types and widths for the frame statistics stage and its comparator.
package cmp_pkg;

  localparam int CNT_W  = 8;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

endpackage

// File: rtl/mag_cmp4.sv
// Purely combinational unsigned 4-bit magnitude comparator (a against b).
module mag_cmp4
  import cmp_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              eq,
  output logic              gt,
  output logic              lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_frame_stats.sv
// Frame statistics stage: classifies FRAME_LEN samples against a per-frame
// threshold, tracks min/max and presents one result record per frame.
module cmp_frame_stats
  import cmp_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] thr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_gt_cnt,
  output logic [CNT_W-1:0]  out_eq_cnt,
  output logic [CNT_W-1:0]  out_lt_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [CNT_W-1:0]  gt_q, gt_d;
  logic [CNT_W-1:0]  eq_q, eq_d;
  logic [CNT_W-1:0]  lt_q, lt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] thr_sel;
  logic              s_eq, s_gt, s_lt;
  logic              min_eq, min_gt, min_lt;
  logic              max_eq, max_gt, max_lt;
  logic              min_upd, max_upd;

  // The first sample of a frame is classified against the live threshold,
  // because thr_q only captures it on that same edge.
  assign thr_sel = (state_q == IDLE) ? thr : thr_q;

  mag_cmp4 u_cmp_thr (.a(in_data), .b(thr_sel), .eq(s_eq),   .gt(s_gt),   .lt(s_lt));
  mag_cmp4 u_cmp_min (.a(in_data), .b(min_q),   .eq(min_eq), .gt(min_gt), .lt(min_lt));
  mag_cmp4 u_cmp_max (.a(in_data), .b(max_q),   .eq(max_eq), .gt(max_gt), .lt(max_lt));

  assign min_upd = min_lt & ~min_eq & ~min_gt;
  assign max_upd = max_gt & ~max_eq & ~max_lt;

  assign in_ready   = (state_q != HOLD);
  assign out_valid  = (state_q == HOLD);
  assign out_min    = min_q;
  assign out_max    = max_q;
  assign out_gt_cnt = gt_q;
  assign out_eq_cnt = eq_q;
  assign out_lt_cnt = lt_q;

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    min_d   = min_q;
    max_d   = max_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          thr_d   = thr;
          min_d   = in_data;
          max_d   = in_data;
          gt_d    = CNT_W'(s_gt);
          eq_d    = CNT_W'(s_eq);
          lt_d    = CNT_W'(s_lt);
          cnt_d   = CNT_W'(1);
          state_d = (FRAME_LEN == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (min_upd) min_d = in_data;
          if (max_upd) max_d = in_data;
          gt_d  = gt_q + CNT_W'(s_gt);
          eq_d  = eq_q + CNT_W'(s_eq);
          lt_d  = lt_q + CNT_W'(s_lt);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == LAST_CNT) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          min_d   = '1;
          max_d   = '0;
          gt_d    = '0;
          eq_d    = '0;
          lt_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      thr_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      gt_q    <= '0;
      eq_q    <= '0;
      lt_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      min_q   <= min_d;
      max_q   <= max_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/cmp_frame_stats.md
# cmp_frame_stats

Streaming statistics stage around the 4-bit magnitude comparator. It accepts a frame of FRAME_LEN unsigned 4-bit samples over a valid/ready handshake. For each frame it classifies every sample against a threshold that is latched at the start of the frame, as greater, equal or less. It also tracks the frame minimum and maximum, then presents one result record on an output valid/ready handshake to the downstream control logic.

## Interface
- FRAME_LEN, 8: samples per frame; legal range 1..255.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- thr  in  4  comparison threshold; sampled only on the first accepted sample of a frame.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  4  unsigned sample.
- out_valid  out  1  result record valid.
- out_ready  in  1  downstream accepts record.
- out_min  out  4  smallest sample in frame.
- out_max  out  4  largest sample in frame.
- out_gt_cnt  out  8  number of samples with sample > threshold.
- out_eq_cnt  out  8  number of samples with sample == threshold.
- out_lt_cnt  out  8  number of samples with sample < threshold.

## Operation
- Transfer occurs on a rising edge with valid && ready, on either port.
- FSM states:
  - IDLE: in_ready=1. On accept: thr_q<=thr; min,max<=in_data; the sample is classified against thr (the live input, not thr_q); cnt<=1. Go to ACCUM, or to HOLD if FRAME_LEN==1.
  - ACCUM: in_ready=1. On accept: classify against thr_q; min<=in_data if in_data<min; max<=in_data if in_data>max; cnt++. When cnt reaches FRAME_LEN, go to HOLD.
  - HOLD: in_ready=0, out_valid=1. On out_ready: go to IDLE and clear the counts.
- Exactly one of gt/eq/lt increments per accepted sample. Invariant at HOLD: gt+eq+lt == FRAME_LEN.
- All comparisons are unsigned 4-bit. Ties do not update min or max.
- Counters are 8 bits. FRAME_LEN<=255, so no overflow or wrap-around occurs.
- thr changes during ACCUM or HOLD are ignored.
- Result outputs are stable while out_valid=1 && out_ready=0.
- Reset applied mid-frame or during HOLD discards the partial or pending frame and returns to IDLE.
- Reset values: in_ready=1 (the first cycle after reset), out_valid=0, out_min=4'hF, out_max=4'h0, all counts 0.

## Timing
- out_valid rises on the edge that accepts the FRAME_LEN-th sample, so it is visible the cycle after the last input handshake.
- Minimum record handshake is 1 cycle in HOLD. in_ready returns high the cycle after the output handshake.
- Peak throughput is FRAME_LEN samples per FRAME_LEN+1 cycles; the one-cycle bubble per frame is required.
- in_ready and out_valid are register-driven, decoded from the state register only. No combinational path from out_ready to in_ready.
- in_valid low mid-frame stalls accumulation indefinitely with no state change.

## Structure
- Shared package cmp_pkg:
  - State enum {IDLE, ACCUM, HOLD}.
  - CNT_W=8.
  - DATA_W=4.
- Sub-module mag_cmp4: purely combinational 4-bit eq/gt/lt comparator, instantiated three times:
  - sample vs threshold mux (thr in IDLE, thr_q otherwise);
  - sample vs min;
  - sample vs max.
- The top level holds the FSM, counters and result registers.

## Test plan
- FRAME_LEN=4, thr=5, samples 3,5,9,5 back-to-back -> min=3, max=9, gt=1, eq=2, lt=1, out_valid one cycle after the 4th accept.
- FRAME_LEN=4, thr=0, samples 15,0,15,0, with out_ready held low 5 cycles -> record stable over the stall; in_ready=0 throughout; min=0, max=15, gt=2, eq=2, lt=0.
- FRAME_LEN=4, thr=7 at frame start, thr changed to 0 after the first accept; samples 7,8,6,7 -> gt=1, eq=2, lt=1.
- FRAME_LEN=1, thr=4, sample 4 -> IDLE to HOLD directly; min=max=4, eq=1; next frame accepted the cycle after the output handshake.
- FRAME_LEN=4: accept 2 samples, pull rst_n low 1 cycle -> out_valid=0, reset values shown; next 4 samples 1,2,3,4 with thr=2 yield min=1, max=4, gt=2, eq=1, lt=1.
- Random in_valid/out_ready gaps over 1000 frames against a scoreboard model -> no lost or duplicated samples, and the count invariant holds.
